parity: RTL and testbench



---
 rtl/parity_pkg.sv | 15 +
 rtl/parity.sv | 90 +++++++++
 tb/tb_parity.sv | 137 +++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity tracker.
//
// Contents:
//   parity_state_t      two-state Moore encoding, EVEN=0 and ODD=1
//   PARITY_RESET_STATE  state loaded by a reset edge
package parity_pkg;

  typedef enum logic {
    S_EVEN = 1'b0,
    S_ODD  = 1'b1
  } parity_state_t;

  localparam parity_state_t PARITY_RESET_STATE = S_EVEN;

endpackage

// File: rtl/parity.sv
// Serial parity tracker: keeps a running odd/even parity of every io_in=1
// accepted since the last reset. Each non-reset clock edge consumes exactly
// one io_in bit. io_out is decoded from the state register only, so there is
// no combinational path from io_in to io_out.
//
// Optional build macro: PARITY_STATS_EN
//   When defined, the module gains parameter CNT_W (1..32, default 16) and the
//   output io_count, a ones-counter that wraps modulo 2^CNT_W.
//   When undefined, the port list is exactly clock, reset, io_in, io_out.
//
// Ports:
//   clock     in   1      system clock, rising-edge active
//   reset     in   1      synchronous, active-high; takes priority over io_in
//   io_in     in   1      serial data bit sampled on every rising edge
//   io_out    out  1      1 = odd number of ones since reset, 0 = even
//   io_count  out  CNT_W  (PARITY_STATS_EN only) ones accepted since reset
module parity
  import parity_pkg::*;
`ifdef PARITY_STATS_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in,
  output logic             io_out
`ifdef PARITY_STATS_EN
  ,
  output logic [CNT_W-1:0] io_count
`endif
);

  parity_state_t state;
  parity_state_t state_nxt;

`ifdef PARITY_STATS_EN
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  // Natural wrap on overflow keeps io_out == count[0] for every width.
  function automatic logic [CNT_W-1:0] count_inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(1);
  endfunction
`endif

  always_comb begin
    state_nxt = state;
    if (io_in) begin
      state_nxt = (state == S_ODD) ? S_EVEN : S_ODD;
    end
  end

`ifdef PARITY_STATS_EN
  always_comb begin
    count_nxt = count;
    if (io_in) begin
      count_nxt = count_inc(count);
    end
  end
`endif

  // ---- register stage: parity state (and ones-counter) ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= PARITY_RESET_STATE;
`ifdef PARITY_STATS_EN
      count <= '0;
`endif
    end else begin
      state <= state_nxt;
`ifdef PARITY_STATS_EN
      count <= count_nxt;
`endif
    end
  end

  // ---- output decode from registered state ----
  always_comb begin
    io_out = (state == S_ODD);
  end

`ifdef PARITY_STATS_EN
  always_comb begin
    io_count = count;
  end
`endif

endmodule

// File: tb/tb_parity.sv
// Scoreboard bench for parity. The stimulus process drives one bit per cycle,
// tracks the total number of ones accepted since reset as a plain integer and
// pushes the expected parity (and wrapped count when PARITY_STATS_EN is
// defined) after every edge. A separate monitor pops and compares one entry
// #1 after each rising edge.
module tb_parity;

`ifdef PARITY_STATS_EN
  localparam int CNT_W = 2;
`endif

  typedef struct {
    logic        out;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  logic clock;
  logic reset;
  logic io_in;
  logic io_out;
`ifdef PARITY_STATS_EN
  logic [CNT_W-1:0] io_count;
`endif

  exp_t   q[$];
  int     checks = 0;
  int     passes = 0;
  longint ones   = 0;
  string  cur_tag = "init";

`ifdef PARITY_STATS_EN
  parity #(.CNT_W(CNT_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_count (io_count)
  );
`else
  parity dut (
    .clock  (clock),
    .reset  (reset),
    .io_in  (io_in),
    .io_out (io_out)
  );
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One cycle of stimulus; the reference is simply "ones seen since reset".
  task automatic step(input logic r, input logic d);
    exp_t e;
    @(negedge clock);
    reset = r;
    io_in = d;
    @(posedge clock);
    if (r) ones = 0;
    else if (d) ones = ones + 1;
    e.out = logic'(ones % 2);
`ifdef PARITY_STATS_EN
    e.cnt = 32'(ones % (longint'(1) << CNT_W));
`else
    e.cnt = 32'(ones);
`endif
    e.tag = cur_tag;
    q.push_back(e);
  endtask

  task automatic run_bits(input string tag, input logic [31:0] bits, input int n);
    cur_tag = tag;
    for (int i = n - 1; i >= 0; i--) step(1'b0, bits[i]);
  endtask

  // Monitor: output is valid on every cycle after a reset edge.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (io_out === e.out) passes++;
      else $display("FAIL %s io_out: got %b expected %b", e.tag, io_out, e.out);
`ifdef PARITY_STATS_EN
      checks++;
      if (io_count === e.cnt[CNT_W-1:0]) passes++;
      else $display("FAIL %s io_count: got %0d expected %0d", e.tag, io_count, e.cnt[CNT_W-1:0]);
      checks++;
      if (io_out === io_count[0]) passes++;
      else $display("FAIL %s invariant: io_out %b io_count[0] %b", e.tag, io_out, io_count[0]);
`endif
    end
  end

  initial begin
    reset = 1'b1;
    io_in = 1'b1;

    cur_tag = "reset_hold";
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    run_bits("single_one", 32'b10, 2);
    cur_tag = "reset2";
    step(1'b1, 1'b0);
    run_bits("toggle5", 32'b11111, 5);
    cur_tag = "reset3";
    step(1'b1, 1'b0);
    run_bits("mixed", 32'b1001101, 7);
    cur_tag = "reset4";
    step(1'b1, 1'b0);
    run_bits("mid_pre", 32'b111, 3);
    cur_tag = "mid_reset";
    step(1'b1, 1'b1);
    run_bits("mid_post", 32'b1, 1);
    cur_tag = "reset5";
    step(1'b1, 1'b0);
    run_bits("five_ones", 32'b11111, 5);

    cur_tag = "random";
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), logic'($urandom_range(0, 1)));
    end

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clock);
    #2;
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL drain: %0d entries left, expected 0", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
